// File: rtl/prob_3_31_a.sv
// prob_3_31_a: registered F(A,B,C,D) = sum m(0,2,4,8,10,12,14)
// Core is NOR(d, NOR(a, ~b, ~c)); result is held in one flop.
//
// Ports:
//   f     - registered function result (0 while in reset)
//   a     - variable A, MSB of minterm index
//   b     - variable B
//   c     - variable C
//   d     - variable D, LSB of minterm index
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
module prob_3_31_a (
    output logic f,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic clk,
    input  logic rst_n
);

    logic b_n;
    logic c_n;
    logic n1;
    logic f_d;
    logic f_q;

    assign b_n = ~b;
    assign c_n = ~c;

    // Gate 1 yields A'BC, the only region where D' alone is not enough
    assign n1  = ~(a | b_n | c_n);

    // Gate 2 kills the output whenever D is set or A'BC holds
    assign f_d = ~(d | n1);

    // Reset clears to 0 even though F(0000) = 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_d;
        end
    end

    assign f = f_q;

endmodule

// File: tb/tb_prob_3_31_a.sv
// tb_prob_3_31_a: table-driven check of prob_3_31_a
// Expected values come from constants in the bench, queued per edge.
module tb_prob_3_31_a;

    logic f;
    logic a;
    logic b;
    logic c;
    logic d;
    logic clk;
    logic rst_n;

    typedef struct {
        logic       rst;
        logic [3:0] abcd;
        logic       exp;
        string      name;
    } vec_t;

    typedef struct {
        logic  exp;
        string name;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_vec;
    int   n_bad;

    prob_3_31_a dut (
        .f     (f),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input logic e, input string nm);
        n_vec++;
        if (f !== e) begin
            n_bad++;
            $display("FAIL %s: f=%b expected %b", nm, f, e);
        end
    endtask

    task automatic pop_check();
        sb_t s;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: empty queue");
        end else begin
            s = sb.pop_front();
            check_now(s.exp, s.name);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] v,
                         input logic e, input string nm);
        sb_t s;
        @(negedge clk);
        rst_n = r;
        {a, b, c, d} = v;
        s.exp = e;
        s.name = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic add(input logic r, input logic [3:0] v,
                       input logic e, input string nm);
        vec_t t;
        t.rst = r;
        t.abcd = v;
        t.exp = e;
        t.name = nm;
        tbl.push_back(t);
    endtask

    initial begin
        int sweep_exp[16] = '{1, 0, 1, 0, 1, 0, 0, 0,
                              1, 0, 1, 0, 1, 0, 1, 0};
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        {a, b, c, d} = 4'b0000;

        // reset held with F(0000)=1 on the inputs, then release
        for (int i = 0; i < 3; i++)
            add(1'b0, 4'd0, 1'b0, $sformatf("reset_hold%0d", i));
        add(1'b1, 4'd0, 1'b1, "reset_release");

        for (int i = 0; i < 16; i++)
            add(1'b1, 4'(i), 1'(sweep_exp[i]), $sformatf("sweep_%0d", i));

        for (int i = 0; i < 8; i++)
            add(1'b1, {3'(i), 1'b1}, 1'b0, $sformatf("d_dom_%0d", i));

        add(1'b1, 4'd6,  1'b0, "abc_term_6");
        add(1'b1, 4'd14, 1'b1, "abc_term_14");
        add(1'b1, 4'd4,  1'b1, "abc_term_4");
        add(1'b1, 4'd2,  1'b1, "abc_term_2");

        // mid-sweep reset: 8 gives 1, reset at 10 forces 0, 12 recovers
        add(1'b1, 4'd8,  1'b1, "mid_pre_8");
        add(1'b0, 4'd10, 1'b0, "mid_rst_10");
        add(1'b1, 4'd12, 1'b1, "mid_post_12");

        foreach (tbl[i])
            apply(tbl[i].rst, tbl[i].abcd, tbl[i].exp, tbl[i].name);

        // back-to-back alternation 0 -> 6 -> 0 (1,0,1)
        apply(1'b1, 4'd0, 1'b1, "b2b_0");
        apply(1'b1, 4'd6, 1'b0, "b2b_6");
        apply(1'b1, 4'd0, 1'b1, "b2b_0b");

        // inter-edge glitch on d while abc=000: f must not move
        apply(1'b1, 4'd0, 1'b1, "glitch_base");
        #1;
        d = 1'b1;
        #1;
        check_now(1'b1, "glitch_d_high");
        #1;
        d = 1'b0;
        #1;
        check_now(1'b1, "glitch_d_low");
        @(posedge clk);
        #1;
        check_now(1'b1, "glitch_next_edge");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prob_3_31_a.md
# prob_3_31_a

Registered four-input Boolean function block. It evaluates F(A,B,C,D) = Σm(0,2,4,8,10,12,14), built as a two-NOR-gate network, and presents the result on a clocked output. It sits as a leaf cell in the combinational-logic exercise set. Any bench can drive its inputs exhaustively and check the clocked result one cycle later.

## Interface
- No parameters.
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- f  output  1  registered function result.
- a  input  1  variable A, MSB of minterm index.
- b  input  1  variable B.
- c  input  1  variable C.
- d  input  1  variable D, LSB of minterm index.
- Declaration order is f, a, b, c, d, clk, rst_n, so positional instances that bind (f, a, b, c, d) stay valid.

## Operation
- Minterm index is {a,b,c,d}, range 0..15.
- Truth function:
  - F = 1 for indices 0, 2, 4, 8, 10, 12, 14.
  - F = 0 for indices 1, 3, 5, 6, 7, 9, 11, 13, 15.
- The textbook don't-cares at 0, 1, 5, 8 are resolved as 0→1, 1→0, 5→0, 8→1. This choice is fixed.
- Minimal form: F = D'·(A + B' + C') = NOR(D, NOR(A, B', C')).
- The combinational core is structural:
  - Gate 1: 3-input NOR of a, ~b, ~c, giving n1 = A'BC.
  - Gate 2: 2-input NOR of d and n1, giving F.
  - Inverters on b and c are permitted; no other logic is allowed in the core.
- Output register:
  - f_q <= F(a,b,c,d) on every posedge when rst_n = 1.
  - f_q <= 0 on any posedge when rst_n = 0.
  - f = f_q.
- The block has no enable, no other state, and no internal handshake.
- X or Z on any input propagates per gate semantics. No masking is applied.

## Timing
- Latency: exactly 1 clock. f after posedge k equals F of the a..d values sampled at posedge k.
- Inputs must be stable within setup/hold around each posedge. Changes between edges do not affect f until the next edge.
- Reset value of f: 0.
  - This holds even though F(0000) = 1.
  - f stays 0 on every edge where rst_n = 0.
- Reset release: on the first posedge with rst_n = 1, f takes F of the inputs sampled at that edge.
- Reset mid-operation: the next edge with rst_n = 0 forces f = 0 regardless of inputs. No other state exists to recover.
- Simultaneous input change and edge: the standard sampled value at the edge is used. There is no glitch filtering.
- Throughput: one new evaluation per clock. Back-to-back distinct vectors are each reflected on consecutive cycles.

## Test plan
- Reset: hold rst_n = 0 with {a,b,c,d} = 0000 for 3 edges → f = 0 throughout, despite F(0000) = 1. Release → f = 1 after the first active edge.
- Exhaustive sweep: apply indices 0..15 in ascending order, one per clock, every 10 ns → f sequence 1,0,1,0,1,0,0,0,1,0,1,0,1,0,1,0, each lagging input by one cycle.
- D dominance: drive d = 1 with every combination of a, b, c → f = 0 on all 8 vectors.
- A'BC term: index 6 (0110) → f = 0. Index 14 (1110) → f = 1. Index 4 (0100) → f = 1. Index 2 (0010) → f = 1.
- Mid-sweep reset: at index 10, assert rst_n = 0 for one edge → f = 0 that cycle. Index 12 on the next edge with rst_n = 1 → f = 1.
- Inter-edge glitch: toggle d 0→1→0 between two posedges while abc = 000 → f remains 1. No change is visible on f.
